// File: rtl/ras_ckpt_stack.sv
// Return-address stack for the branch predictor: circular buffer with overwrite-on-overflow
// and NR_CKPT tagged checkpoints that repair tos/count/top after a misprediction.
module ras_ckpt_stack #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned NR_CKPT = 4,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CID_W  = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] data_o,
  output logic              valid_o,
  output logic [PTR_W:0]    count_o,
  input  logic              ckpt_save_i,
  input  logic [CID_W-1:0]  ckpt_id_i,
  input  logic              restore_i,
  input  logic [CID_W-1:0]  restore_id_i,
  output logic              restore_miss_o
);

  localparam logic [PTR_W-1:0] LastIdx  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   DepthCnt = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [PTR_W-1:0]  tos;
    logic [PTR_W:0]    cnt;
    logic [ADDR_W-1:0] top;
  } ckpt_t;

  logic [ADDR_W-1:0] entry_q [DEPTH];
  logic [ADDR_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  ckpt_t             ckpt_q [NR_CKPT];
  ckpt_t             ckpt_d [NR_CKPT];
  logic [NR_CKPT-1:0] ckpt_vld_q, ckpt_vld_d;
  logic              miss_q, miss_d;

  logic [PTR_W-1:0]  tos_inc, tos_dec;
  logic              save_id_ok, rest_id_ok;
  logic              rest_hit;
  ckpt_t             rest_slot;
  ckpt_t             live_snap;

  // Slot ids beyond NR_CKPT only exist when NR_CKPT is not a power of two.
  if (NR_CKPT == (2 ** CID_W)) begin : g_id_full
    assign save_id_ok = 1'b1;
    assign rest_id_ok = 1'b1;
  end else begin : g_id_part
    assign save_id_ok = (ckpt_id_i < CID_W'(NR_CKPT));
    assign rest_id_ok = (restore_id_i < CID_W'(NR_CKPT));
  end

  // Compare-based wrap so non-power-of-two depths wrap exactly at DEPTH.
  always_comb begin
    tos_inc = (tos_q == LastIdx) ? '0 : tos_q + PtrOne;
    tos_dec = (tos_q == '0) ? LastIdx : tos_q - PtrOne;
  end

  always_comb begin
    rest_slot = ckpt_q[restore_id_i];
    rest_hit  = rest_id_ok && ckpt_vld_q[restore_id_i];
    live_snap = '{tos: tos_q, cnt: cnt_q, top: entry_q[tos_q]};
  end

  always_comb begin
    entry_d    = entry_q;
    tos_d      = tos_q;
    cnt_d      = cnt_q;
    ckpt_d     = ckpt_q;
    ckpt_vld_d = ckpt_vld_q;
    miss_d     = 1'b0;

    if (flush_i) begin
      tos_d      = '0;
      cnt_d      = '0;
      ckpt_vld_d = '0;
    end else if (restore_i) begin
      if (rest_hit) begin
        tos_d                  = rest_slot.tos;
        cnt_d                  = rest_slot.cnt;
        entry_d[rest_slot.tos] = rest_slot.top;
      end else begin
        // Miss empties the live stack but keeps the other checkpoints.
        tos_d  = '0;
        cnt_d  = '0;
        miss_d = 1'b1;
      end
    end else begin
      if (ckpt_save_i && save_id_ok) begin
        ckpt_d[ckpt_id_i]     = live_snap;
        ckpt_vld_d[ckpt_id_i] = 1'b1;
      end

      if (push_i && pop_i && (cnt_q != '0)) begin
        entry_d[tos_q] = data_i;
      end else if (push_i) begin
        tos_d            = tos_inc;
        entry_d[tos_inc] = data_i;
        if (cnt_q != DepthCnt) begin
          cnt_d = cnt_q + CntOne;
        end
      end else if (pop_i && (cnt_q != '0)) begin
        tos_d = tos_dec;
        cnt_d = cnt_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
      for (int i = 0; i < int'(NR_CKPT); i++) begin
        ckpt_q[i] <= '0;
      end
      tos_q      <= '0;
      cnt_q      <= '0;
      ckpt_vld_q <= '0;
      miss_q     <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      ckpt_q     <= ckpt_d;
      tos_q      <= tos_d;
      cnt_q      <= cnt_d;
      ckpt_vld_q <= ckpt_vld_d;
      miss_q     <= miss_d;
    end
  end

  // Top is not masked when empty; consumers qualify with valid_o.
  always_comb begin
    data_o         = entry_q[tos_q];
    valid_o        = (cnt_q != '0);
    count_o        = cnt_q;
    restore_miss_o = miss_q;
  end

endmodule
